// File: rtl/board_scan_ctrl.sv
// board_scan_ctrl: maps VGA pixel coordinates onto Tetris board cells.
// Each in-board pixel reads its cell type from the board RAM, passes that
// type through the external colour LUT and registers the colour for the DAC.
// Game logic shares the RAM read port on cycles the scanout leaves idle.
//
// Pixel latency is 4 cycles.
//   cycle c   : pixel on pix_x/pix_y/pix_active
//   cycle c+1 : ram_addr (scanout address or granted game address), gl_gnt
//   cycle c+2 : ram_rd_type valid
//   cycle c+3 : lut_type, gl_rvalid, gl_type
//   cycle c+4 : pix_color
//
// Optional macro GRID_LINES_EN: the first pixel row and the first pixel
// column of every cell are drawn as grey grid lines (12'h333). The latency
// does not change.
//
// Game read handshake: gl_req is a level request that must be held, together
// with gl_addr, until gl_gnt is seen. gl_gnt pulses for one cycle in the cycle
// where gl_addr is on ram_addr. gl_rvalid pulses two cycles later, with
// gl_type. Every cycle in which gl_req is sampled high while scanout leaves
// the port free is a separate request. A requester that keeps gl_req high
// therefore gets back-to-back grants, each followed by its own rvalid pulse.
module board_scan_ctrl #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int CELL_SHIFT = 4,
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 80,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_active,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [2:0]        ram_rd_type,
  output logic [2:0]        lut_type,
  input  logic [11:0]       lut_color,
  output logic [11:0]       pix_color,
  input  logic              gl_req,
  input  logic [ADDR_W-1:0] gl_addr,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic [2:0]        gl_type
);

  localparam logic [9:0]  ORG_X  = 10'(ORIGIN_X);
  localparam logic [9:0]  ORG_Y  = 10'(ORIGIN_Y);
  localparam logic [10:0] SPAN_X = 11'(BOARD_W << CELL_SHIFT);
  localparam logic [10:0] SPAN_Y = 11'(BOARD_H << CELL_SHIFT);

  // Offsets wrap when the pixel is left of or above the board. The wrapped
  // value is large and fails the span compare, so one unsigned compare per
  // axis is enough.
  logic [9:0]        dx, dy;
  logic [9:0]        col, row;
  logic              in_board;
  logic [ADDR_W-1:0] scan_addr;

  assign dx        = pix_x - ORG_X;
  assign dy        = pix_y - ORG_Y;
  assign in_board  = pix_active && ({1'b0, dx} < SPAN_X) && ({1'b0, dy} < SPAN_Y);
  assign col       = dx >> CELL_SHIFT;
  assign row       = dy >> CELL_SHIFT;
  assign scan_addr = ADDR_W'(row) * ADDR_W'(BOARD_W) + ADDR_W'(col);

  // Flags that travel with the pixel through the pipeline.
  logic ib1, ib2, ib3;
  logic gnt_d;

  // S1: port arbitration. Scanout always owns the port; game logic uses it
  // only on out-of-board or blanking cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr <= '0;
      gl_gnt   <= 1'b0;
      ib1      <= 1'b0;
    end else begin
      ib1    <= in_board;
      gl_gnt <= !in_board && gl_req;
      if (in_board) begin
        ram_addr <= scan_addr;
      end else if (gl_req) begin
        ram_addr <= gl_addr;
      end
    end
  end

  // S2: the RAM samples ram_addr here; delay the flags to line up with its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ib2   <= 1'b0;
      gnt_d <= 1'b0;
    end else begin
      ib2   <= ib1;
      gnt_d <= gl_gnt;
    end
  end

  // S3: route the RAM data to the LUT (scanout) or to gl_type (game read).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_type  <= '0;
      gl_rvalid <= 1'b0;
      gl_type   <= '0;
      ib3       <= 1'b0;
    end else begin
      ib3       <= ib2;
      lut_type  <= ib2 ? ram_rd_type : 3'd0;
      gl_rvalid <= gnt_d;
      if (gnt_d) begin
        gl_type <= ram_rd_type;
      end
    end
  end

`ifdef GRID_LINES_EN
  // The grid flag marks offset 0 inside a cell on either axis.
  logic grid0, grid1, grid2, grid3;
  assign grid0 = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);

  // The grid flag follows the same pipeline as in_board.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grid1 <= 1'b0;
      grid2 <= 1'b0;
      grid3 <= 1'b0;
    end else begin
      grid1 <= grid0;
      grid2 <= grid1;
      grid3 <= grid2;
    end
  end

  // S4: register the colour. Out-of-board pixels and blanking are black.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_color <= '0;
    end else if (ib3) begin
      pix_color <= grid3 ? 12'h333 : lut_color;
    end else begin
      pix_color <= 12'h000;
    end
  end
`else
  // S4: register the colour. Out-of-board pixels and blanking are black.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_color <= '0;
    end else begin
      pix_color <= ib3 ? lut_color : 12'h000;
    end
  end
`endif

endmodule
